pc_call_stack: RTL
==================

Name: pc_call_stack

Overview:
- Parametrised program counter with an integrated hardware return-address stack (LIFO).
- Adds call and return on top of the existing load / increment / reset operations.
- `call` pushes the return address and jumps; `ret` pops and resumes.
- Sits in the CPU fetch path in place of the plain counter. Drives the instruction-memory address.

Parameters:
- WIDTH, 16, bit width of the PC, `in_value` and stack entries.
- DEPTH, 8, number of return-address stack entries. Must be >= 1.
- CNT_W, $clog2(DEPTH+1), width of the depth count. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- in_value  input  WIDTH  jump/call target.
- load  input  1  PC <= in_value.
- increment  input  1  PC <= PC + 1.
- call  input  1  push PC+1, then PC <= in_value.
- ret  input  1  PC <= popped top of stack.
- out  output  WIDTH  current PC.
- depth  output  CNT_W  number of valid stack entries.
- stack_empty  output  1  depth == 0.
- stack_full  output  1  depth == DEPTH.
- overflow  output  1  sticky: a call was made while full.
- underflow  output  1  sticky: a ret was made while empty.

Behaviour:
- All state updates on posedge clk only. `out`, `depth` and the flags are registered or derived from registers, with no combinational path from inputs to outputs.
- Reset values: out = 0, depth = 0, overflow = 0, underflow = 0, stack_empty = 1, stack_full = 0. Stack contents are don't-care after reset.
- Reset mid-sequence discards all stack contents on that edge.
- Per-cycle priority, one operation per cycle: reset > call > ret > load > increment > hold.
  - Lower-priority requests in the same cycle are ignored. They are not queued.
- call, not full:
  - mem[depth] <= out + 1, mod 2^WIDTH.
  - depth <= depth + 1.
  - out <= in_value.
- call, full:
  - out <= in_value; no push; depth unchanged; overflow <= 1.
  - Existing entries are preserved; the return address is lost.
- ret, not empty: out <= mem[depth-1]; depth <= depth - 1.
- ret, empty: out unchanged; depth stays 0; underflow <= 1.
- load: out <= in_value; stack untouched.
- increment: out <= out + 1, wrapping from 2^WIDTH-1 to 0. Stack untouched.
- Return-address arithmetic also wraps: a call at out = 2^WIDTH-1 pushes 0.
- overflow and underflow are sticky. They clear only on reset.
- Latency: one cycle for every operation. The new `out` is visible the cycle after the requesting edge.
- Back-to-back call/ret on consecutive cycles is fully supported, with no bubbles.
- Stack is a register array indexed by depth; no read-before-write hazard arises because only one op occurs per cycle.

Decomposition:
- Shared package pc_pkg:
  - Operation encoding enum: OP_HOLD, OP_INC, OP_LOAD, OP_RET, OP_CALL, OP_RESET.
  - Priority-select function mapping the request bits to an op.
  - Used by this block and by the fetch-stage control decoder.
- One sub-module: lifo_stack.
  - Parameters WIDTH and DEPTH.
  - Inputs: push, pop, push_data.
  - Outputs: top, depth, empty, full.
  - Ignores push-when-full and pop-when-empty.
- pc_call_stack owns the PC register, the priority logic and the sticky flags.

Test Plan (WIDTH=16, DEPTH=4 unless stated):
- Reset then increment x3 -> out = 0,1,2,3; depth = 0; stack_empty = 1; no flags.
- Nested calls, then returns:
  - Stimulus: at out=0x0010, call in_value=0x0100; at out=0x0100, call in_value=0x0200; then ret, ret.
  - Required: out sequence 0x0100, 0x0200, 0x0101, 0x0011; depth 1, 2, 1, 0.
- Overflow:
  - Stimulus: five calls with targets 0x1000..0x1004 from distinct PCs.
  - Required: fifth call sets out = 0x1004, depth stays 4, stack_full = 1, overflow = 1.
  - Then four rets return the first four return addresses in LIFO order; overflow stays 1.
- Underflow and wrap:
  - Stimulus: ret on empty stack at out = 0x0042.
  - Required: out stays 0x0042, underflow = 1.
  - Stimulus: load 0xFFFF, then call 0x0005, then ret.
  - Required: ret yields out = 0x0000.
- Simultaneous requests:
  - call + ret + load + increment in one cycle -> only the call acts.
  - ret + load on a non-empty stack -> the pop wins and in_value is ignored.
  - reset + call -> all reset values; nothing pushed.
- Reset mid-operation: after 3 pushes and overflow = 1, assert reset -> depth = 0, out = 0, overflow = 0. A subsequent ret sets underflow = 1.

Source files
------------

// File: rtl/pc_pkg.sv
// ============================================================================
// pc_pkg : shared PC operation encoding and request priority select
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_INC   = 3'd1,
    OP_LOAD  = 3'd2,
    OP_RET   = 3'd3,
    OP_CALL  = 3'd4,
    OP_RESET = 3'd5
  } pc_op_e;

  // One op per cycle; anything below the winner is dropped, not queued.
  function automatic pc_op_e pc_sel_op(input logic reset_req,
                                       input logic call_req,
                                       input logic ret_req,
                                       input logic load_req,
                                       input logic inc_req);
    pc_op_e op;
    if (reset_req)     op = OP_RESET;
    else if (call_req) op = OP_CALL;
    else if (ret_req)  op = OP_RET;
    else if (load_req) op = OP_LOAD;
    else if (inc_req)  op = OP_INC;
    else               op = OP_HOLD;
    return op;
  endfunction

endpackage : pc_pkg

`default_nettype wire

// File: rtl/lifo_stack.sv
// ============================================================================
// lifo_stack : register-array LIFO; push-when-full and pop-when-empty ignored
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lifo_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CNT_W-1:0] depth_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] depth_q;
  logic [CNT_W-1:0] depth_d;
  logic [CNT_W-1:0] rd_cnt;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (depth_q == '0);
  assign full_o  = (depth_q == C_DEPTH);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;

  assign rd_cnt = depth_q - CNT_W'(1);
  assign wr_idx = depth_q[IDX_W-1:0];
  assign rd_idx = rd_cnt[IDX_W-1:0];

  always_comb begin
    depth_d = depth_q;
    if (do_push)     depth_d = depth_q + CNT_W'(1);
    else if (do_pop) depth_d = rd_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  // Entries are never reset; depth alone decides which ones are valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_idx] <= push_data_i;
  end

  assign top_o   = empty_o ? '0 : mem_q[rd_idx];
  assign depth_o = depth_q;

endmodule : lifo_stack

`default_nettype wire

// File: rtl/pc_call_stack.sv
// ============================================================================
// pc_call_stack : program counter with hardware return-address stack
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pc_call_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_value,
  input  logic             load,
  input  logic             increment,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] depth,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             overflow,
  output logic             underflow
);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] stk_top;
  logic             ovf_q;
  logic             unf_q;

  assign op     = pc_sel_op(reset, call, ret, load, increment);
  assign pc_inc = pc_q + WIDTH'(1);

  lifo_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (op == OP_CALL),
    .pop_i       (op == OP_RET),
    .push_data_i (pc_inc),
    .top_o       (stk_top),
    .depth_o     (depth),
    .empty_o     (stack_empty),
    .full_o      (stack_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      case (op)
        OP_CALL: begin
          pc_q <= in_value;
          if (stack_full) ovf_q <= 1'b1;
        end
        OP_RET: begin
          if (stack_empty) unf_q <= 1'b1;
          else             pc_q  <= stk_top;
        end
        OP_LOAD: pc_q <= in_value;
        OP_INC:  pc_q <= pc_inc;
        default: pc_q <= pc_q;
      endcase
    end
  end

  assign out       = pc_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule : pc_call_stack

`default_nettype wire
